// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto the configuration-chain head with a chain clock enable.
// Optional CRC-16-CCITT trailer check is compiled in with `define CCFF_LOADER_CRC_EN.
//  state   | meaning
//  IDLE    | waiting for start
//  LOAD    | requesting the next word (chain clock gated off)
//  SHIFT   | driving one bit per cycle into the chain
//  CHECK   | requesting the CRC trailer word (CRC build only)
//  DONE    | CHAIN_LEN bits delivered, waiting for start
module ccff_bitstream_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              cfg_clk_en,
   output logic              busy,
   output logic              done,
   output logic              error
);
   localparam int WB_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CHECK, S_DONE} state_t;

`ifdef CCFF_LOADER_CRC_EN
   localparam state_t S_AFTER = S_CHECK;
`else
   localparam state_t S_AFTER = S_DONE;
`endif

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WB_W-1:0]    word_bits_q, word_bits_d;
   logic               head_q, head_d;
   logic [CNT_W-1:0]   remain;
   logic               accept;
   logic               last_bit;
   logic               idle_start;

   assign remain     = CHAIN_LEN_C - bit_cnt_q;
   assign accept     = word_valid & word_ready;
   assign last_bit   = (state_q == S_SHIFT) && (word_bits_q == WB_W'(1));
   assign idle_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

   always_ff @(posedge prog_clk) begin
      if (!prog_rst_n) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         word_bits_q <= '0;
         head_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         word_bits_q <= word_bits_d;
         head_q      <= head_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_LOAD;
         S_LOAD:         if (accept) state_d = S_SHIFT;
         S_SHIFT:        if (last_bit) state_d = (bit_cnt_q == LAST_C) ? S_AFTER : S_LOAD;
         S_CHECK:        if (accept) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   // The head register only advances while more bits of the word remain, so it
   // holds the last driven bit through the LOAD bubble and in DONE.
   always_comb begin
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      word_bits_d = word_bits_q;
      head_d      = head_q;
      if (idle_start) bit_cnt_d = '0;
      if (state_q == S_LOAD && accept) begin
         head_d      = word_data[WORD_W-1];
         shreg_d     = word_data << 1;
         word_bits_d = (remain >= WORD_W_C) ? WB_W'(WORD_W) : WB_W'(remain);
      end
      if (state_q == S_SHIFT) begin
         bit_cnt_d   = bit_cnt_q + CNT_W'(1);
         word_bits_d = word_bits_q - WB_W'(1);
         if (!last_bit) begin
            head_d  = shreg_q[WORD_W-1];
            shreg_d = shreg_q << 1;
         end
      end
   end

   always_comb begin
      word_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
      cfg_clk_en = (state_q == S_SHIFT);
      busy       = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_CHECK);
      done       = (state_q == S_DONE);
      ccff_head  = head_q;
   end

`ifdef CCFF_LOADER_CRC_EN
   logic [15:0] crc_q, crc_d;
   logic        error_q, error_d;

   always_ff @(posedge prog_clk) begin
      if (!prog_rst_n) begin
         crc_q   <= 16'hFFFF;
         error_q <= 1'b0;
      end else begin
         crc_q   <= crc_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      crc_d   = crc_q;
      error_d = error_q;
      if (idle_start) begin
         crc_d   = 16'hFFFF;
         error_d = 1'b0;
      end
      if (state_q == S_SHIFT)
         crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ head_q) ? 16'h1021 : 16'h0000);
      if (state_q == S_CHECK && accept)
         error_d = (word_data[15:0] != crc_q);
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: bit-stream queue model, chain model and directed loads.
// CRC trailer checks are included when CCFF_LOADER_CRC_EN is defined.
module tb_ccff_bitstream_loader;
   localparam int CL = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] word_data;
   logic       word_valid;
   logic       word_ready, ccff_head, cfg_clk_en, busy, done, error;

   always #5 clk = ~clk;

   ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(CL), .CNT_W(16)) u_dut (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .word_data(word_data),
      .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
      .cfg_clk_en(cfg_clk_en), .busy(busy), .done(done), .error(error));

   logic       start8, valid8;
   logic [7:0] data8;
   logic       ready8, head8, en8, busy8, done8, err8;

   ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(8), .CNT_W(16)) u_dut8 (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start8), .word_data(data8),
      .word_valid(valid8), .word_ready(ready8), .ccff_head(head8),
      .cfg_clk_en(en8), .busy(busy8), .done(done8), .error(err8));

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: the exact bit sequence the chain must receive, plus the chain itself.
   bit         exp_q[$];
   logic [7:0] feed_q[$];
   int         en_cnt, gap, acc_cnt;
   bit         strict_bubble, final_seen, acc_pend;
   logic [CL-1:0] chain = '0;

   always @(posedge clk) if (cfg_clk_en) chain <= {chain[CL-2:0], ccff_head};

   always @(negedge clk) acc_pend = word_valid && word_ready && rst_n;

   initial begin
      word_valid = 1'b0;
      word_data  = 8'h00;
      acc_cnt    = 0;
      forever begin
         @(posedge clk); #1;
         if (acc_pend && feed_q.size() > 0) begin
            void'(feed_q.pop_front());
            acc_cnt++;
         end
         word_valid = (feed_q.size() > 0);
         word_data  = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
      end
   end

   always @(negedge clk) begin
      if (final_seen) begin
         chk("done_after_last", done, 1);
         chk("en_after_last", cfg_clk_en, 0);
      end
      final_seen = 0;
      if (cfg_clk_en) begin
         if (exp_q.size() == 0) chk("extra_bit", en_cnt + 1, CL);
         else chk($sformatf("bit%0d", en_cnt), ccff_head, exp_q.pop_front());
         if (en_cnt > 0 && gap > 0) begin
            chk("bubble_pos", en_cnt % 8, 0);
            if (strict_bubble) chk("bubble_len", gap, 1);
         end
         chk("done_low_in_shift", done, 0);
         gap = 0;
         en_cnt++;
         if (en_cnt == CL) final_seen = 1;
      end else if (en_cnt > 0 && en_cnt < CL) begin
         gap++;
      end
   end

   function automatic logic [CL-1:0] pack_exp();
      logic [CL-1:0] v = '0;
      foreach (exp_q[i]) v = {v[CL-2:0], exp_q[i]};
      return v;
   endfunction

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic begin_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input bit gapped);
      logic [7:0] w[3];
      w[0] = a; w[1] = b; w[2] = c;
      exp_q.delete();
      for (int i = 0; i < 3; i++)
         for (int k = 7; k >= 0; k--)
            if (exp_q.size() < CL) exp_q.push_back(w[i][k]);
      en_cnt = 0; gap = 0; final_seen = 0; strict_bubble = !gapped;
      feed_q.delete();
      feed_q.push_back(a);
      feed_q.push_back(b);
      if (!gapped) feed_q.push_back(c);
      acc_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_en(input int target);
      int n = 0;
      while (en_cnt < target && n < 200) begin tick(); n++; end
      chk("wait_en_timeout", (en_cnt >= target), 1);
   endtask

   task automatic finish_load(input logic [CL-1:0] exp_chain, input int words);
      int n = 0;
      while (!done && n < 200) begin tick(); n++; end
      chk("done_timeout", done, 1);
      chk("en_count", en_cnt, CL);
      chk("model_drained", exp_q.size(), 0);
      chk("chain", chain, exp_chain);
      chk("words_taken", acc_cnt, words);
      chk("busy_in_done", busy, 0);
      chk("ready_in_done", word_ready, 0);
      chk("error_in_done", error, 0);
      repeat (3) tick();
      chk("done_held", done, 1);
      chk("en_held_low", cfg_clk_en, 0);
   endtask

`ifdef CCFF_LOADER_CRC_EN
   logic        c_start, c_valid;
   logic [15:0] c_data;
   logic        c_ready, c_head, c_en, c_busy, c_done, c_err;

   ccff_bitstream_loader #(.WORD_W(16), .CHAIN_LEN(16), .CNT_W(16)) u_crc (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(c_start), .word_data(c_data),
      .word_valid(c_valid), .word_ready(c_ready), .ccff_head(c_head),
      .cfg_clk_en(c_en), .busy(c_busy), .done(c_done), .error(c_err));

   function automatic logic [15:0] crc16(input logic [15:0] d);
      logic [15:0] c = 16'hFFFF;
      for (int i = 15; i >= 0; i--)
         c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction

   task automatic crc_run(input logic [15:0] cw, input logic exp_err);
      int  acc = 0;
      bit  wa;
      c_data = 16'h1234; c_valid = 1'b1; c_start = 1'b1;
      tick();
      c_start = 1'b0;
      for (int n = 0; n < 80 && !c_done; n++) begin
         wa = c_ready;
         @(posedge clk); #1;
         if (wa) begin acc++; c_data = cw; end
         tick();
      end
      chk("crc_done", c_done, 1);
      chk("crc_error", c_err, exp_err);
      chk("crc_words", acc, 2);
      c_valid = 1'b0;
   endtask
`endif

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0;
      start8 = 1'b0; valid8 = 1'b1; data8 = 8'h81;
`ifdef CCFF_LOADER_CRC_EN
      c_start = 1'b0; c_valid = 1'b0; c_data = 16'h0;
`endif
      en_cnt = 0; gap = 0; final_seen = 0; strict_bubble = 1;
      repeat (3) tick();
      chk("rst_ready", word_ready, 0);
      chk("rst_en", cfg_clk_en, 0);
      chk("rst_head", ccff_head, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // basic load
      begin_load(8'hA5, 8'h3C, 8'hF0, 0);
      chk("model_pin", pack_exp(), 20'hA53CF);
      finish_load(20'hA53CF, 3);

      // backpressure: valid low for five LOAD cycles before the third word
      begin_load(8'hA5, 8'h3C, 8'hF0, 1);
      begin
         int n = 0;
         while (acc_cnt < 2 && n < 100) begin tick(); n++; end
         chk("bp_two_words", acc_cnt, 2);
         n = 0;
         while (!word_ready && n < 40) begin tick(); n++; end
         chk("bp_reached_load", word_ready, 1);
         for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("bp_en_low", cfg_clk_en, 0);
            chk("bp_head_hold", ccff_head, 0);
         end
         feed_q.push_back(8'hF0);
      end
      finish_load(20'hA53CF, 3);

      // control abuse: start during SHIFT, then reset at bit 11
      begin_load(8'hA5, 8'h3C, 8'hF0, 0);
      wait_en(3);
      chk("busy_in_shift", busy, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_en(11);
      rst_n = 1'b0;
      tick();
      chk("abort_ready", word_ready, 0);
      chk("abort_en", cfg_clk_en, 0);
      chk("abort_head", ccff_head, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_error", error, 0);
      exp_q.delete();
      feed_q.delete();
      en_cnt = 0; gap = 0;
      rst_n = 1'b1;
      repeat (2) tick();
      chk("abort_idle_en", cfg_clk_en, 0);
      begin_load(8'hA5, 8'h3C, 8'hF0, 0);
      finish_load(20'hA53CF, 3);

      // overwrite the chain
      begin_load(8'hFF, 8'hFF, 8'hF0, 0);
      finish_load(20'hFFFFF, 3);

      // single-word chain
      begin
         logic [7:0] bits8 = '0;
         int nb = 0, nr = 0;
         start8 = 1'b1;
         tick();
         start8 = 1'b0;
         for (int n = 0; n < 40 && !done8; n++) begin
            if (en8) begin bits8 = {bits8[6:0], head8}; nb++; end
            if (ready8) nr++;
            tick();
         end
         chk("w8_done", done8, 1);
         chk("w8_bits", bits8, 8'h81);
         chk("w8_en_count", nb, 8);
         chk("w8_requests", nr, 1);
         nr = 0;
         repeat (4) begin if (ready8 || en8) nr++; tick(); end
         chk("w8_quiet_after", nr, 0);
      end

`ifdef CCFF_LOADER_CRC_EN
      chk("crc_model_pin", crc16(16'h1234), 16'h0EC9);
      crc_run(16'h0EC9, 1'b0);
      crc_run(16'h0EC8, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
